// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined multi-mode barrel shifter.
package shift_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_op_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

  // Barrel levels handled between two consecutive pipeline registers.
  function automatic int levels_per_group(input int shw, input int nregs);
    return (shw + nregs - 1) / nregs;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: shifts or rotates by DIST when en_i is set.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  shift_op_e        op_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        SLL:     data_o = data_i << DIST;
        SRL:     data_o = data_i >> DIST;
        SRA:     data_o = $signed(data_i) >>> DIST;
        ROL:     data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
        ROR:     data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        // Illegal ops pass the operand through untouched at every level.
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SHW levels split into NUM_REGS register-terminated
// groups, with a tag carried alongside and whole-pipe valid/ready stalling.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 2,
  parameter int TAG_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int LPG = levels_per_group(SHW, NUM_REGS);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [TAG_W-1:0] tag;
    shift_op_e        op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           in_rec;
  stage_t           grp_in   [NUM_REGS];
  stage_t           stage_d  [NUM_REGS];
  stage_t           stage_q  [NUM_REGS];
  logic [WIDTH-1:0] grp_out  [NUM_REGS];
  logic [WIDTH-1:0] lvl_out  [SHW];
  logic             adv;
  logic             unused_tail;

  // Handshake: a beat transfers on any edge where valid & ready are both high.
  // The whole pipe advances together when the output slot is empty or being
  // drained, so bubbles are held in place during a stall rather than squeezed out.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    in_rec       = '0;
    in_rec.valid = in_valid;
    in_rec.err   = in_valid & ~is_legal_op(in_op);
    in_rec.tag   = in_tag;
    in_rec.op    = shift_op_e'(in_op);
    in_rec.shamt = in_shamt;
    in_rec.data  = in_a;
  end

  always_comb begin
    grp_in[0] = in_rec;
    for (int g = 1; g < NUM_REGS; g++) begin
      grp_in[g] = stage_q[g-1];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int G = k / LPG;
    logic [WIDTH-1:0] lvl_in;
    if (k % LPG == 0) begin : g_first
      assign lvl_in = grp_in[G].data;
    end else begin : g_chain
      assign lvl_in = lvl_out[k-1];
    end
    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data_i (lvl_in),
      .en_i   (grp_in[G].shamt[k]),
      .op_i   (grp_in[G].op),
      .data_o (lvl_out[k])
    );
  end

  // Trailing groups can be empty when SHW does not fill every group.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_grp
    localparam int LO = g * LPG;
    localparam int HI = (((g + 1) * LPG < SHW) ? (g + 1) * LPG : SHW) - 1;
    if (LO < SHW) begin : g_busy
      assign grp_out[g] = lvl_out[HI];
    end else begin : g_empty
      assign grp_out[g] = grp_in[g].data;
    end
  end

  always_comb begin
    for (int g = 0; g < NUM_REGS; g++) begin
      stage_d[g]      = grp_in[g];
      stage_d[g].data = grp_out[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_REGS; g++) begin
        stage_q[g] <= '0;
      end
    end else if (adv) begin
      for (int g = 0; g < NUM_REGS; g++) begin
        stage_q[g] <= stage_d[g];
      end
    end
  end

  assign out_valid = stage_q[NUM_REGS-1].valid;
  assign out_y     = stage_q[NUM_REGS-1].data;
  assign out_tag   = stage_q[NUM_REGS-1].tag;
  assign out_err   = stage_q[NUM_REGS-1].err;
  assign out_zero  = (stage_q[NUM_REGS-1].data == '0);

  // Op and shift amount are fully consumed by the time a beat reaches the end.
  assign unused_tail = ^{stage_q[NUM_REGS-1].op, stage_q[NUM_REGS-1].shamt};

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboarded bench for shift_pipe: directed 32-bit vectors plus randomised
// sweeps of an 8-bit/1-stage and a 64-bit/6-stage build.
module tb_shift_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic sweep_go = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [31:0] in_a, out_y;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  // {y[31:0], tag[3:0], err, check_latency}
  logic [37:0] exp_q[$];
  int          acc_q[$];

  shift_pipe #(.WIDTH(32), .NUM_REGS(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [63:0] a_in, input int sh,
                                            input logic [2:0] op, input int w);
    logic [63:0]        mask, a, r;
    logic signed [63:0] s;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    s    = $signed(a << (64 - w)) >>> (64 - w);
    case (op)
      3'd0:    r = a << sh;
      3'd1:    r = a >> sh;
      3'd2:    r = s >>> sh;
      3'd3:    r = (a << sh) | (a >> (w - sh));
      3'd4:    r = (a >> sh) | (a << (w - sh));
      default: r = a;
    endcase
    return r & mask;
  endfunction

  task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic [2:0] op,
                      input logic [3:0] tag, input logic [31:0] ey, input logic ee,
                      input logic lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
    #4;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #4;
      guard++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept tag%0d: in_ready stuck at 0, 1 required", tag);
    end else begin
      exp_q.push_back({ey, tag, ee, lat});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int i;
    @(negedge clk);
    in_valid = 1'b0;
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d results outstanding, 0 required", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // Monitor for the 32-bit build: pops on every output handshake and also
  // checks stall behaviour whenever the result is held.
  initial begin : mon32
    logic [37:0] e;
    logic [36:0] held;
    logic        stall_prev;
    int          acc;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      #4;
      if (out_valid && !out_ready) begin
        check("in_ready during stall", 64'(in_ready), 64'd0);
        if (stall_prev) check("held output", 64'({out_y, out_tag, out_err}), 64'(held));
        held       = {out_y, out_tag, out_err};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected output: got y=0x%0h tag%0d, expected none", out_y, out_tag);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          check($sformatf("y tag%0d", e[5:2]), 64'(out_y), 64'(e[37:6]));
          check($sformatf("tag order tag%0d", e[5:2]), 64'(out_tag), 64'(e[5:2]));
          check($sformatf("err tag%0d", e[5:2]), 64'(out_err), 64'(e[1]));
          check($sformatf("zero tag%0d", e[5:2]), 64'(out_zero), 64'(e[37:6] == 32'd0));
          if (e[0]) check($sformatf("latency tag%0d", e[5:2]), 64'(cyc - acc), 64'd2);
        end
      end
    end
  end

  // Randomised sweeps of two other configurations against ref_model.
  for (genvar c = 0; c < 2; c++) begin : g_sweep
    localparam int SW  = (c == 0) ? 8 : 64;
    localparam int SR  = (c == 0) ? 1 : 6;
    localparam int SSH = $clog2(SW);

    logic            s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_zero, s_out_err;
    logic [SW-1:0]   s_in_a, s_out_y;
    logic [SSH-1:0]  s_in_shamt;
    logic [2:0]      s_in_op;
    logic [3:0]      s_in_tag, s_out_tag;
    logic            fin = 1'b0;
    logic [SW+4:0]   exp_q[$];

    shift_pipe #(.WIDTH(SW), .NUM_REGS(SR), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_shamt(s_in_shamt), .in_op(s_in_op), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_y(s_out_y), .out_tag(s_out_tag), .out_zero(s_out_zero), .out_err(s_out_err)
    );

    initial begin : drv
      logic [63:0] rv, ry;
      int          sh, guard;
      logic [2:0]  op;
      logic [3:0]  tg;
      s_in_valid = 1'b0;
      s_in_a     = '0;
      s_in_shamt = '0;
      s_in_op    = '0;
      s_in_tag   = '0;
      wait (sweep_go);
      for (int n = 0; n < 60; n++) begin
        @(negedge clk);
        if ($urandom_range(0, 4) == 0) begin
          s_in_valid = 1'b0;
          @(negedge clk);
        end
        rv = {$urandom(), $urandom()};
        sh = $urandom_range(0, SW - 1);
        op = 3'($urandom_range(0, 7));
        tg = 4'(n);
        ry = ref_model(rv, sh, op, SW);
        s_in_valid = 1'b1;
        s_in_a     = rv[SW-1:0];
        s_in_shamt = SSH'(sh);
        s_in_op    = op;
        s_in_tag   = tg;
        #4;
        guard = 0;
        while (!s_in_ready && guard < 100) begin
          @(negedge clk);
          #4;
          guard++;
        end
        if (!s_in_ready) begin
          vectors++;
          miscompares++;
          $display("FAIL sweep%0d accept: in_ready stuck at 0, 1 required", SW);
        end else begin
          exp_q.push_back({ry[SW-1:0], tg, (op > 3'd4)});
        end
        @(posedge clk);
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sweep%0d drain: %0d outstanding, 0 required", SW, exp_q.size());
      end
      fin = 1'b1;
    end

    initial begin : stall
      s_out_ready = 1'b1;
      wait (sweep_go);
      while (!fin) begin
        @(negedge clk);
        s_out_ready = ($urandom_range(0, 3) != 0);
      end
      s_out_ready = 1'b1;
    end

    initial begin : mon
      logic [SW+4:0] e;
      wait (sweep_go);
      forever begin
        @(negedge clk);
        #4;
        if (s_out_valid && s_out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sweep%0d unexpected output: got y=0x%0h, expected none", SW, s_out_y);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("sweep%0d y tag%0d", SW, e[4:1]), 64'(s_out_y), 64'(e[SW+4:5]));
            check($sformatf("sweep%0d tag", SW), 64'(s_out_tag), 64'(e[4:1]));
            check($sformatf("sweep%0d err tag%0d", SW, e[4:1]), 64'(s_out_err), 64'(e[0]));
            check($sformatf("sweep%0d zero tag%0d", SW, e[4:1]), 64'(s_out_zero),
                  64'(e[SW+4:5] == '0));
          end
        end
      end
    end
  end

  initial begin : main
    int i;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_shamt  = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_y", 64'(out_y), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    check("reset out_err", 64'(out_err), 64'd0);
    check("reset out_zero", 64'(out_zero), 64'd1);
    check("reset in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Isolated SRA beats with latency checks.
    send(32'h87654321, 5'd31, 3'b010, 4'd1, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_drain();
    send(32'hA5A5A5A5, 5'd13, 3'b010, 4'd2, 32'hFFFD2D2D, 1'b0, 1'b1);
    wait_drain();

    // Back-to-back stream, tags 1..5.
    send(32'h0000000F, 5'd2, 3'b000, 4'd1, 32'h0000003C, 1'b0, 1'b1);
    send(32'h87654321, 5'd4, 3'b001, 4'd2, 32'h08765432, 1'b0, 1'b1);
    send(32'hA5A5A5A5, 5'd1, 3'b011, 4'd3, 32'h4B4B4B4B, 1'b0, 1'b1);
    send(32'h12345678, 5'd8, 3'b100, 4'd4, 32'h78123456, 1'b0, 1'b1);
    send(32'h80000000, 5'd1, 3'b000, 4'd5, 32'h00000000, 1'b0, 1'b1);
    wait_drain();

    // Five-cycle backpressure in the middle of a stream.
    fork
      begin
        send(32'hF0000000, 5'd31, 3'b001, 4'd6,  32'h00000001, 1'b0, 1'b0);
        send(32'h00000001, 5'd31, 3'b000, 4'd7,  32'h80000000, 1'b0, 1'b0);
        send(32'h00000001, 5'd1,  3'b100, 4'd8,  32'h80000000, 1'b0, 1'b0);
        send(32'h80000000, 5'd1,  3'b011, 4'd9,  32'h00000001, 1'b0, 1'b0);
        send(32'h7FFFFFFF, 5'd30, 3'b010, 4'd10, 32'h00000001, 1'b0, 1'b0);
        send(32'h80000000, 5'd16, 3'b010, 4'd11, 32'hFFFF8000, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Illegal ops pass the operand through; shift by zero is identity.
    send(32'hDEADBEEF, 5'd3, 3'b110, 4'd12, 32'hDEADBEEF, 1'b1, 1'b0);
    send(32'h00000000, 5'd7, 3'b101, 4'd13, 32'h00000000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send(32'hC3A50F1E, 5'd0, 3'(k), 4'(k), 32'hC3A50F1E, 1'b0, 1'b0);
    end
    wait_drain();

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h11112222;
    in_shamt = 5'd0;
    in_op    = 3'b000;
    in_tag   = 4'hE;
    @(posedge clk);
    @(negedge clk);
    in_tag = 4'hF;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset out_y", 64'(out_y), 64'd0);
    check("async reset out_tag", 64'(out_tag), 64'd0);
    check("async reset out_err", 64'(out_err), 64'd0);
    check("async reset out_zero", 64'(out_zero), 64'd1);
    check("async reset in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #4;
    check("post-reset out_valid", 64'(out_valid), 64'd0);

    sweep_go = 1'b1;
    i = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin) && i < 20000) begin
      @(negedge clk);
      i++;
    end
    if (!(g_sweep[0].fin && g_sweep[1].fin)) begin
      vectors++;
      miscompares++;
      $display("FAIL sweep timeout: sweeps unfinished after %0d cycles", i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined multi-mode barrel shifter for the SimpleALU datapath. It generalises the fixed 32-bit combinational arithmetic-right shifter to any power-of-two width and five shift/rotate modes. It adds a configurable number of register stages, valid/ready flow control and a passthrough tag. It sits between operand issue and ALU writeback. Downstream stalls propagate back to issue through the handshake.

## Interface
- WIDTH, 32: data width; power of two, ≥ 4
- NUM_REGS, 2: pipeline register stages, 1..$clog2(WIDTH); equals latency
- TAG_W, 4: width of sideband tag carried alongside data
- Derived (localparam): SHW = $clog2(WIDTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_a  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, unsigned
- in_op  in  3  mode (shift_pkg::shift_op_e)
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_tag  out  TAG_W  tag of this result
- out_zero  out  1  out_y == 0
- out_err  out  1  in_op was illegal

## Operation
- Op encoding:
  - 000 SLL: zero fill.
  - 001 SRL: zero fill.
  - 010 SRA: fill with in_a[WIDTH-1].
  - 011 ROL.
  - 100 ROR.
  - 101–111 illegal: out_y = in_a unmodified, out_err = 1.
- Shift amount 0: out_y = in_a for every mode, out_err = 0 for legal ops.
- The SHW barrel levels are ordered LSB-first; level k shifts by 2^k when in_shamt[k] = 1.
- Level groups:
  - Levels are split into NUM_REGS groups of ceil(SHW/NUM_REGS) levels.
  - The last group may be smaller.
  - A register follows each group.
- Each stage register holds: data, remaining shamt bits, op, tag, err, valid.
- out_zero is computed combinationally from the last stage register's data.
- Flow control:
  - adv = ~out_valid | out_ready. All stages load when adv = 1 and hold when adv = 0.
  - in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - When in_valid = 0 on an advancing cycle, a bubble (valid = 0) enters stage 0.
  - Bubbles are not collapsed: a stalled pipeline holds its bubbles too.
- Ordering: results leave in acceptance order. There is no reordering or dropping.

## Timing
- Reset (rst_n low, async):
  - All stage valid bits clear and in-flight beats are discarded.
  - out_valid = 0, out_y = 0, out_tag = 0, out_err = 0, out_zero = 1.
  - in_ready = 1 during and after reset.
- Latency: a beat accepted at edge N presents out_valid = 1 after edge N+NUM_REGS-1, i.e. it is visible in the cycle following NUM_REGS accepting edges.
- Throughput: one beat per cycle while out_ready is held high.
- Stall:
  - While out_valid & ~out_ready, out_y/out_tag/out_err/out_valid are stable.
  - in_ready = 0 in the same cycle (combinational from out_ready).
- Simultaneous out handshake and in accept in one cycle: both occur and the pipeline shifts by one.
- Reset deasserted mid-stream: the block restarts empty. Beats presented before reset are never emitted.

## Structure
- Package shift_pkg:
  - shift_op_e enum: SLL, SRL, SRA, ROL, ROR.
  - function is_legal_op.
  - Stage-record typedef parametrised by width (struct built inside the module via the package helper).
- Sub-module shift_level:
  - One combinational barrel level.
  - Parameters WIDTH and DIST (2^k).
  - Inputs: data, enable bit, op. Output: data.
- shift_pipe generates SHW shift_level instances and NUM_REGS register stages.

## Test plan
- WIDTH=32, NUM_REGS=2, out_ready=1: SRA 0x87654321 by 31 -> 0xFFFFFFFF; SRA 0xA5A5A5A5 by 13 -> 0xFFFD2D2D. Each valid exactly 2 cycles after acceptance.
- Back-to-back stream, tags 1..5, out_ready=1:
  - SLL 0x0000000F by 2 -> 0x0000003C.
  - SRL 0x87654321 by 4 -> 0x08765432.
  - ROL 0xA5A5A5A5 by 1 -> 0x4B4B4B4B.
  - ROR 0x12345678 by 8 -> 0x78123456.
  - SLL 0x80000000 by 1 -> 0x00000000 with out_zero=1.
  - Required: one result per cycle with tags in order 1..5.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream. Required: in_ready=0 while out_valid is high, held output stable, no beat lost or duplicated.
- Illegal op 110 on 0xDEADBEEF by 3 -> out_y=0xDEADBEEF, out_err=1. Shamt 0 with all legal ops returns in_a.
- Assert rst_n=0 asynchronously with 2 beats in flight. Required: out_valid drops immediately, outputs take reset values, nothing is emitted after release.
- Sweep WIDTH=8/NUM_REGS=1 and WIDTH=64/NUM_REGS=6 with random ops, shamts and stalls, scoreboarded against a $signed/>>>/rotate reference model.
